// File: rtl/kernel_bc_write_back_ctrl_pkg.sv
// Shared types and helpers for the kernel_bc write-back controller.
// Holds the FSM state encoding, the OKAY response code and the burst sizing helper.
package kernel_bc_wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } wb_state_e;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  // Beats in the next burst: the remaining count, capped at the burst length.
  function automatic logic [8:0] burst_beats(input logic [31:0] rem, input int unsigned burst_len);
    logic [31:0] cap;
    cap = 32'(burst_len);
    if (rem < cap) return rem[8:0];
    return cap[8:0];
  endfunction

endpackage

// File: rtl/kernel_bc_write_back_ctrl_if.sv
// Burst write channel bundle (address, data, response) between the
// write-back controller (master) and the memory interconnect (slave).
interface kernel_bc_write_back_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
) ();

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/kernel_bc_write_back_ctrl_perf_cnt.sv
// Saturating 32-bit event counter with enable, used for the optional
// performance counters of the write-back controller.
module kernel_bc_wb_perf_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [31:0] count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) return val;
    return val + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/kernel_bc_write_back_ctrl.sv
// Write-back stage of kernel_bc: pops a start token, splits the job into bursts and
// streams result words to the write master. Optional KERNEL_BC_WB_PERF_EN adds perf counters.
module kernel_bc_write_back_ctrl
  import kernel_bc_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] job_base,
  input  logic [31:0]           job_count,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_empty_n,
  output logic                  din_read,
  kernel_bc_write_back_ctrl_if.master axi,
  output logic                  done,
  output logic                  idle,
  output logic                  err,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           rem_r;
  logic [8:0]            beats_r;
  logic [8:0]            burst_r;
  logic                  err_r;
  logic                  awvalid_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic [7:0]            awlen_r;

  logic [ADDR_WIDTH-1:0] addr_step;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [8:0]            load_beats;
  logic                  enter_aw;
  logic                  w_fire;

  assign addr_step = ADDR_WIDTH'(burst_r) << BYTE_SHIFT;
  assign addr_nxt  = addr_r + addr_step;

  always_comb begin
    state_d    = state_q;
    start_read = 1'b0;
    din_read   = 1'b0;
    w_fire     = 1'b0;
    enter_aw   = 1'b0;
    load_addr  = addr_r;
    load_beats = burst_beats(rem_r, BURST_LEN);
    axi.wvalid = 1'b0;
    axi.wdata  = '0;
    axi.wlast  = 1'b0;
    axi.bready = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_read = start_empty_n;
        if (start_empty_n) begin
          if (job_count == 32'd0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_AW;
            enter_aw   = 1'b1;
            load_addr  = job_base;
            load_beats = burst_beats(job_count, BURST_LEN);
          end
        end
      end
      S_AW: begin
        if (axi.awready) state_d = S_W;
      end
      S_W: begin
        axi.wvalid = din_empty_n;
        axi.wdata  = din;
        axi.wlast  = (beats_r == 9'd1);
        w_fire     = din_empty_n & axi.wready;
        din_read   = w_fire;
        if (w_fire && beats_r == 9'd1) state_d = S_B;
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          // rem_r already reflects the burst just written, so it sizes the next one
          if (rem_r != 32'd0) begin
            state_d   = S_AW;
            enter_aw  = 1'b1;
            load_addr = addr_nxt;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_r    <= '0;
      rem_r     <= '0;
      beats_r   <= '0;
      burst_r   <= '0;
      err_r     <= 1'b0;
      awvalid_r <= 1'b0;
      awaddr_r  <= '0;
      awlen_r   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_empty_n) begin
        addr_r <= job_base;
        rem_r  <= job_count;
      end
      // Address channel is registered: loaded on entry to AW, held until awready
      if (enter_aw) begin
        awvalid_r <= 1'b1;
        awaddr_r  <= load_addr;
        awlen_r   <= 8'(load_beats - 9'd1);
        beats_r   <= load_beats;
        burst_r   <= load_beats;
      end else if (state_q == S_AW && axi.awready) begin
        awvalid_r <= 1'b0;
      end
      if (w_fire) begin
        beats_r <= beats_r - 9'd1;
        rem_r   <= rem_r - 32'd1;
      end
      if (state_q == S_B && axi.bvalid) begin
        addr_r <= addr_nxt;
        if (axi.bresp != BRESP_OKAY) err_r <= 1'b1;
      end
    end
  end

  assign axi.awvalid = awvalid_r;
  assign axi.awaddr  = awaddr_r;
  assign axi.awlen   = awlen_r;
  assign done        = (state_q == S_DONE);
  assign idle        = (state_q == S_IDLE);
  assign err         = err_r;

`ifdef KERNEL_BC_WB_PERF_EN
  kernel_bc_wb_perf_cnt u_busy_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q != S_IDLE),
    .count   (perf_busy_cycles)
  );

  kernel_bc_wb_perf_cnt u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == S_W && !w_fire),
    .count   (perf_stall_cycles)
  );
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// Directed bench for kernel_bc_write_back_ctrl with a scoreboard of expected
// address/data beats and a memory/FIFO responder model.
module tb_kernel_bc_write_back_ctrl;

  localparam int DW = 32;
  localparam int AWD = 64;
  localparam int BL = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start_empty_n;
  logic           start_read;
  logic [AWD-1:0] job_base;
  logic [31:0]    job_count;
  logic [DW-1:0]  din;
  logic           din_empty_n;
  logic           din_read;
  logic           done;
  logic           idle;
  logic           err;
  logic [31:0]    perf_busy_cycles;
  logic [31:0]    perf_stall_cycles;

  always #5 clk = ~clk;

  kernel_bc_write_back_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) axi ();

  kernel_bc_write_back_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AWD),
    .BURST_LEN  (BL)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_empty_n     (start_empty_n),
    .start_read        (start_read),
    .job_base          (job_base),
    .job_count         (job_count),
    .din               (din),
    .din_empty_n       (din_empty_n),
    .din_read          (din_read),
    .axi               (axi.master),
    .done              (done),
    .idle              (idle),
    .err               (err),
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and responder state
  logic [31:0] din_q[$];
  logic [32:0] exp_w[$];
  logic [71:0] exp_aw[$];
  logic [1:0]  bresp_q[$];
  logic [32:0] e_w;
  logic [71:0] e_aw;
  logic [71:0] prev_aw;
  bit tok_pending, gaps, pop_din, pop_tok, b_pending, b_ack, prev_awstall;
  int cyc = 0;
  int done_cnt = 0, din_reads = 0, w_beats = 0, aw_cnt = 0, pop_cyc = 0, done_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      start_empty_n = 1'b0;
      din_empty_n   = 1'b0;
      axi.awready   = 1'b0;
      axi.wready    = 1'b0;
      axi.bvalid    = 1'b0;
      axi.bresp     = 2'b00;
    end else begin
      if (pop_din) begin
        if (din_q.size() > 0) void'(din_q.pop_front());
        pop_din = 1'b0;
      end
      if (pop_tok) begin
        tok_pending = 1'b0;
        pop_tok = 1'b0;
      end
      if (b_ack) begin
        b_pending = 1'b0;
        b_ack = 1'b0;
        if (bresp_q.size() > 0) void'(bresp_q.pop_front());
      end
      start_empty_n = tok_pending;
      din_empty_n   = (din_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
      din           = (din_q.size() > 0) ? din_q[0] : '0;
      axi.awready   = !gaps || ($urandom_range(0, 1) == 1);
      axi.wready    = !gaps || ($urandom_range(0, 3) != 0);
      axi.bvalid    = b_pending && (!gaps || $urandom_range(0, 1) == 1);
      axi.bresp     = (axi.bvalid && bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
      #1;
      if (reset_n) begin
        if (start_read) begin
          pop_tok = 1'b1;
          pop_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (din_read) begin
          din_reads++;
          pop_din = 1'b1;
        end
        if (prev_awstall) chk("aw_hold", 64'(axi.awvalid && {axi.awaddr, axi.awlen} == prev_aw), 1);
        prev_awstall = axi.awvalid && !axi.awready;
        prev_aw = {axi.awaddr, axi.awlen};
        if (axi.awvalid && axi.awready) begin
          aw_cnt++;
          chk("aw_expected", 64'(exp_aw.size() > 0), 1);
          if (exp_aw.size() > 0) begin
            e_aw = exp_aw.pop_front();
            chk("awaddr", axi.awaddr, e_aw[71:8]);
            chk("awlen", 64'(axi.awlen), 64'(e_aw[7:0]));
          end
        end
        if (axi.wvalid && axi.wready) begin
          w_beats++;
          chk("din_read_on_beat", 64'(din_read), 1);
          chk("w_expected", 64'(exp_w.size() > 0), 1);
          if (exp_w.size() > 0) begin
            e_w = exp_w.pop_front();
            chk("wdata", 64'(axi.wdata), 64'(e_w[31:0]));
            chk("wlast", 64'(axi.wlast), 64'(e_w[32]));
          end
          if (axi.wlast) b_pending = 1'b1;
        end
        if (axi.bvalid && axi.bready) b_ack = 1'b1;
      end
    end
  end

  task automatic setup_job(input logic [63:0] base, input int count);
    logic [63:0] a;
    logic [31:0] d;
    int rem;
    int b;
    a = base;
    rem = count;
    while (rem > 0) begin
      b = (rem < BL) ? rem : BL;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int j = 0; j < b; j++) begin
        d = $urandom;
        din_q.push_back(d);
        exp_w.push_back({(j == b - 1), d});
      end
      a = a + 64'(b * (DW / 8));
      rem = rem - b;
    end
    din_reads = 0;
    w_beats = 0;
    job_base = base;
    job_count = count;
    tok_pending = 1'b1;
  endtask

  task automatic wait_done(input int start_cnt, input string tag);
    int n;
    n = 0;
    while (done_cnt == start_cnt && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != start_cnt), 1);
  endtask

  task automatic after_job(input string tag, input int count);
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_aw_left"}, 64'(exp_aw.size()), 0);
    chk({tag, "_w_left"}, 64'(exp_w.size()), 0);
    chk({tag, "_din_reads"}, 64'(din_reads), 64'(count));
    chk({tag, "_idle"}, 64'(idle), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start_read"}, 64'(start_read), 0);
    chk({tag, "_din_read"}, 64'(din_read), 0);
    chk({tag, "_awvalid"}, 64'(axi.awvalid), 0);
    chk({tag, "_wvalid"}, 64'(axi.wvalid), 0);
    chk({tag, "_wlast"}, 64'(axi.wlast), 0);
    chk({tag, "_bready"}, 64'(axi.bready), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_idle"}, 64'(idle), 1);
    chk({tag, "_awaddr"}, axi.awaddr, 0);
    chk({tag, "_awlen"}, 64'(axi.awlen), 0);
    chk({tag, "_wdata"}, 64'(axi.wdata), 0);
  endtask

  int d0;
  int a0;
  int n;

  initial begin
    reset_n = 1'b0;
    tok_pending = 1'b0;
    gaps = 1'b0;
    start_empty_n = 1'b0;
    din_empty_n = 1'b0;
    din = '0;
    job_base = '0;
    job_count = '0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    axi.bresp = 2'b00;
    #1;
    check_reset_vals("por");
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Single short burst, all ready: done 8 cycles after the token pop
    @(posedge clk); #2;
    d0 = done_cnt;
    setup_job(64'h1000, 5);
    wait_done(d0, "j5");
    chk("j5_latency", 64'(done_cyc - pop_cyc), 8);
    after_job("j5", 5);
`ifdef KERNEL_BC_WB_PERF_EN
    chk("perf_busy", 64'(perf_busy_cycles), 8);
    chk("perf_stall", 64'(perf_stall_cycles), 0);
`else
    chk("perf_busy_tied", 64'(perf_busy_cycles), 0);
    chk("perf_stall_tied", 64'(perf_stall_cycles), 0);
`endif

    // Three bursts: 16 + 16 + 8 beats
    d0 = done_cnt;
    a0 = aw_cnt;
    setup_job(64'h1000, 40);
    wait_done(d0, "j40");
    after_job("j40", 40);
    chk("j40_bursts", 64'(aw_cnt - a0), 3);
    chk("j40_single_done", 64'(done_cnt - d0), 1);

    // Zero-count job: done right after the pop, no address traffic
    d0 = done_cnt;
    a0 = aw_cnt;
    setup_job(64'h7000, 0);
    wait_done(d0, "j0");
    chk("j0_latency", 64'(done_cyc - pop_cyc), 1);
    after_job("j0", 0);
    chk("j0_no_aw", 64'(aw_cnt - a0), 0);

    // Random backpressure and FIFO bubbles
    gaps = 1'b1;
    d0 = done_cnt;
    setup_job(64'h2000, 20);
    wait_done(d0, "jgap");
    after_job("jgap", 20);
    chk("jgap_beats", 64'(w_beats), 20);
    gaps = 1'b0;

    // Error response on the first burst does not stop the second
    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b00);
    d0 = done_cnt;
    a0 = aw_cnt;
    setup_job(64'h3000, 32);
    wait_done(d0, "jerr");
    after_job("jerr", 32);
    chk("jerr_bursts", 64'(aw_cnt - a0), 2);
    chk("jerr_err", 64'(err), 1);
    d0 = done_cnt;
    setup_job(64'h4000, 3);
    wait_done(d0, "jerr2");
    after_job("jerr2", 3);
    chk("jerr_sticky", 64'(err), 1);

    // Asynchronous reset in the middle of a data burst
    setup_job(64'h5000, 20);
    n = 0;
    while (w_beats < 3 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk("rst_reach_w", 64'(w_beats >= 3), 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_aw.delete();
    exp_w.delete();
    din_q.delete();
    bresp_q.delete();
    tok_pending = 1'b0;
    pop_din = 1'b0;
    pop_tok = 1'b0;
    b_pending = 1'b0;
    b_ack = 1'b0;
    prev_awstall = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    d0 = done_cnt;
    setup_job(64'h6000, 2);
    wait_done(d0, "jpost");
    after_job("jpost", 2);
    chk("jpost_err_clear", 64'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
